// File: rtl/fast_inv_sqrt_pkg.sv
// Shared definitions for the fast inverse square root chain.
// Holds the sum_sq_accum state encoding, the default Q-format widths shared
// with the inverse-square-root stage, and a small sizing helper.
package fast_inv_sqrt_pkg;

    // Default Q(INT).(FRACT) format shared by every stage of the chain
    localparam int unsigned DEF_INT_WIDTH   = 12;
    localparam int unsigned DEF_FRACT_WIDTH = 4;

    // sum_sq_accum control states
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SQUARE  = 2'd1,
        ACCUM   = 2'd2,
        OUT     = 2'd3
    } sum_sq_state_t;

    // Counter width that stays at least one bit for a single-element vector
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sum_sq_accum_if.sv
// Stream bundle for sum_sq_accum.
// Carries the component input stream (data_in/valid_in/ready_in) and the
// squared-magnitude output stream (data_out/valid_out/ready_out/overflow).
//   master : the environment side (drives components, accepts results)
//   slave  : the sum_sq_accum side
interface sum_sq_accum_if #(
    parameter int unsigned W = fast_inv_sqrt_pkg::DEF_INT_WIDTH + fast_inv_sqrt_pkg::DEF_FRACT_WIDTH
);
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         ready_in;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         ready_out;
    logic         overflow;

    modport master (
        output data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out, overflow
    );

    modport slave (
        input  data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out, overflow
    );
endinterface

// File: rtl/fix_square.sv
// Combinational fixed-point square with Q-format realignment.
// Squares a signed W-bit Q(.FRACT_WIDTH) word into a 2W-bit product carrying
// 2*FRACT_WIDTH fractional bits, then drops FRACT_WIDTH fractional bits by
// truncation so the result is back in the input's fractional scale.
//   comp : signed input component
//   sq   : unsigned aligned square, 2W bits (upper FRACT_WIDTH bits are zero)
module fix_square #(
    parameter int unsigned W           = 16,
    parameter int unsigned FRACT_WIDTH = 4
) (
    input  logic [W-1:0]   comp,
    output logic [2*W-1:0] sq
);
    logic signed [2*W-1:0] comp_ext;
    logic signed [2*W-1:0] prod;

    // Sign-extend so the 2W-bit multiply is exact even for the most negative value
    assign comp_ext = {{W{comp[W-1]}}, comp};
    assign prod     = comp_ext * comp_ext;

    // A square is never negative, so a logical shift is the truncating realignment
    assign sq = $unsigned(prod) >> FRACT_WIDTH;
endmodule

// File: rtl/sum_sq_accum.sv
// Squared-magnitude accumulator feeding the fast inverse square root stage.
// Takes VEC_LEN signed Q(INT_WIDTH).(FRACT_WIDTH) components one at a time,
// squares and accumulates them, and emits |v|^2 in the same Q format.
// Each component takes three cycles (COLLECT -> SQUARE -> ACCUM); after the
// last one the result is held in OUT until the downstream handshake.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus.data_in/valid_in/ready_in       : component input stream
//   bus.data_out/valid_out/ready_out    : squared-magnitude output stream
//   bus.overflow                        : sum exceeded 2^W-1, qualified by valid_out
// Build option: define SUM_SQ_ACCUM_SAT_EN to clamp an overflowing result to
// all ones; otherwise the result wraps modulo 2^W. overflow is reported in both.
module sum_sq_accum
    import fast_inv_sqrt_pkg::*;
#(
    parameter int unsigned INT_WIDTH   = DEF_INT_WIDTH,
    parameter int unsigned FRACT_WIDTH = DEF_FRACT_WIDTH,
    parameter int unsigned VEC_LEN     = 3
) (
    input logic            clk,
    input logic            rst,
    sum_sq_accum_if.slave  bus
);
    localparam int unsigned W     = INT_WIDTH + FRACT_WIDTH;
    localparam int unsigned ACC_W = 2 * W + $clog2(VEC_LEN);
    localparam int unsigned CNT_W = cnt_width(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    sum_sq_state_t    state_q, state_d;
    logic [W-1:0]     comp_q, comp_d;
    logic [2*W-1:0]   sq_q, sq_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_in_q, ready_in_d;
    logic             valid_out_q, valid_out_d;
    logic [W-1:0]     data_out_q, data_out_d;
    logic             overflow_q, overflow_d;

    logic [2*W-1:0]   sq_aligned;
    logic [ACC_W-1:0] acc_next;
    logic             acc_ovf;
    logic [W-1:0]     result;
    logic             accept;
    logic             last_comp;

    // Square path, used only while in SQUARE
    fix_square #(
        .W           (W),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_fix_square (
        .comp (comp_q),
        .sq   (sq_aligned)
    );

    // acc is wide enough that this sum never wraps
    assign acc_next  = acc_q + ACC_W'(sq_q);
    assign acc_ovf   = |acc_next[ACC_W-1:W];
    assign accept    = bus.valid_in && ready_in_q;
    assign last_comp = (count_q == LAST_IDX);

`ifdef SUM_SQ_ACCUM_SAT_EN
    // Clamp to the largest representable value on overflow
    assign result = acc_ovf ? {W{1'b1}} : acc_next[W-1:0];
`else
    // Modulo-2^W wrap
    assign result = acc_next[W-1:0];
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept) state_d = SQUARE;
            SQUARE:  state_d = ACCUM;
            ACCUM:   state_d = last_comp ? OUT : COLLECT;
            OUT:     if (bus.ready_out) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Datapath and output register next values
    always_comb begin
        comp_d      = comp_q;
        sq_d        = sq_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ready_in_d  = ready_in_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            COLLECT: begin
                // ready_in also rises here on the first edge after reset release
                ready_in_d = 1'b1;
                if (accept) begin
                    comp_d     = bus.data_in;
                    ready_in_d = 1'b0;
                end
            end
            SQUARE: begin
                sq_d = sq_aligned;
            end
            ACCUM: begin
                acc_d   = acc_next;
                count_d = count_q + CNT_W'(1);
                if (last_comp) begin
                    data_out_d  = result;
                    overflow_d  = acc_ovf;
                    valid_out_d = 1'b1;
                end else begin
                    ready_in_d = 1'b1;
                end
            end
            OUT: begin
                // Clear the accumulator on handoff so the next vector starts fresh
                if (bus.ready_out) begin
                    valid_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    acc_d       = '0;
                    count_d     = '0;
                    ready_in_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_q      <= '0;
            sq_q        <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            ready_in_q  <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            comp_q      <= comp_d;
            sq_q        <= sq_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ready_in_q  <= ready_in_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.ready_in  = ready_in_q;
    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_sum_sq_accum.sv
// Self-checking bench for sum_sq_accum (INT_WIDTH=12, FRACT_WIDTH=4, VEC_LEN=3).
// Directed table of vectors, hand-written reset sequences, then random vectors
// checked against an arithmetic sum-of-squares reference.
module tb_sum_sq_accum;
    localparam int unsigned W = 16;

`ifdef SUM_SQ_ACCUM_SAT_EN
    localparam logic        SAT = 1'b1;
`else
    localparam logic        SAT = 1'b0;
`endif

    typedef struct {
        logic [2:0][15:0] c;
        logic [15:0]      d;
        logic             o;
        int               hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    sum_sq_accum_if #(.W(W)) bus ();

    sum_sq_accum #(
        .INT_WIDTH   (12),
        .FRACT_WIDTH (4),
        .VEC_LEN     (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: sum of truncated squares in unbounded integer arithmetic
    function automatic void model(input logic [2:0][15:0] c, output logic [15:0] d, output logic o);
        longint s = 0;
        for (int i = 0; i < 3; i++) begin
            longint v = longint'($signed(c[i]));
            s += (v * v) / 16;
        end
        o = (s > 65535);
        d = (o && SAT) ? 16'hFFFF : 16'(s);
    endfunction

    function automatic vec_t mk(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                                input logic [15:0] d, input logic o, input int hold);
        vec_t v;
        v.c[0] = c0; v.c[1] = c1; v.c[2] = c2;
        v.d = d; v.o = o; v.hold = hold;
        return v;
    endfunction

    // Waits (bounded) for ready_in, then offers one component for a single edge
    task automatic send(input logic [15:0] c, input logic garbage, output int waited);
        int k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (bus.ready_in === 1'b1) break;
            k++;
        end
        if (k >= 20) check("ready_in_timeout", 32'd0, 32'd1);
        waited = k;
        bus.valid_in = 1'b1;
        bus.data_in  = c;
        @(posedge clk);
        #1;
        bus.valid_in = garbage;
        bus.data_in  = 16'($urandom);
    endtask

    task automatic run_vector(input string name, input logic [2:0][15:0] c, input logic [15:0] ed,
                              input logic eo, input int hold, input bit chk_first, input bit garbage);
        int w;
        bus.ready_out = (hold == 0);
        for (int i = 0; i < 3; i++) begin
            send(c[i], (i < 2) ? garbage : 1'b0, w);
            if (i > 0) check({name, ":gap"}, 32'(w), 32'd2);
            else if (chk_first) check({name, ":first_gap"}, 32'(w), 32'd0);
        end
        @(negedge clk);
        check({name, ":lat_e0"}, {bus.valid_out, bus.ready_in}, 2'b00);
        @(negedge clk);
        check({name, ":lat_e1"}, {bus.valid_out, bus.ready_in}, 2'b00);
        @(negedge clk);
        check({name, ":valid"}, {bus.valid_out, bus.ready_in}, 2'b10);
        check({name, ":data"}, bus.data_out, ed);
        check({name, ":ovf"}, bus.overflow, eo);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, ":hold"}, {bus.valid_out, bus.ready_in, bus.overflow, bus.data_out},
                  {1'b1, 1'b0, eo, ed});
        end
        bus.ready_out = 1'b1;
        @(posedge clk);
        #1;
        check({name, ":released"}, {bus.valid_out, bus.ready_in, bus.overflow}, 3'b010);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ":rst_outs"}, {bus.ready_in, bus.valid_out, bus.overflow, bus.data_out}, '0);
    endtask

    task automatic release_reset(input string name);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({name, ":rdy_before_edge"}, bus.ready_in, 1'b0);
        @(negedge clk);
        check({name, ":rdy_after_edge"}, bus.ready_in, 1'b1);
    endtask

    initial begin
        vec_t tab[8];
        int   w;
        logic [2:0][15:0] rc;
        logic [15:0] rd;
        logic ro;

        rst           = 1'b1;
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.ready_out = 1'b0;

        tab[0] = mk(16'h0010, 16'h0020, 16'h0020, 16'h0090, 1'b0, 0);
        tab[1] = mk(16'hFFD0, 16'h0040, 16'h0000, 16'h0190, 1'b0, 0);
        tab[2] = mk(16'h0004, 16'h0004, 16'h0004, 16'h0003, 1'b0, 0);
        tab[3] = mk(16'h0400, 16'h0400, 16'h0400, SAT ? 16'hFFFF : 16'h0000, 1'b1, 0);
        tab[4] = mk(16'h0010, 16'h0020, 16'h0020, 16'h0090, 1'b0, 5);
        tab[5] = mk(16'h0010, 16'h0010, 16'h0010, 16'h0030, 1'b0, 0);
        tab[6] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2);
        tab[7] = mk(16'h8000, 16'h0000, 16'h0000, SAT ? 16'hFFFF : 16'h0000, 1'b1, 1);

        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        release_reset("init");

        for (int i = 0; i < 8; i++) begin
            run_vector($sformatf("tab%0d", i), tab[i].c, tab[i].d, tab[i].o, tab[i].hold,
                       i > 0, 1'b1);
        end

        // Reset after two of three components: partial sum must be discarded
        bus.ready_out = 1'b1;
        send(16'h0010, 1'b0, w);
        send(16'h0020, 1'b0, w);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_vec");
        repeat (2) @(negedge clk);
        release_reset("mid_vec");
        rc[0] = 16'h0010; rc[1] = 16'h0010; rc[2] = 16'h0010;
        run_vector("after_mid_rst", rc, 16'h0030, 1'b0, 0, 1'b1, 1'b0);

        // Reset while a result is waiting for the downstream
        bus.ready_out = 1'b0;
        send(16'h0010, 1'b0, w);
        send(16'h0020, 1'b0, w);
        send(16'h0020, 1'b0, w);
        repeat (3) @(negedge clk);
        check("out_wait:data", {bus.valid_out, bus.data_out}, {1'b1, 16'h0090});
        rst = 1'b1;
        #1;
        check_reset_outputs("out_wait");
        release_reset("out_wait");
        run_vector("after_out_rst", rc, 16'h0030, 1'b0, 1, 1'b1, 1'b1);

        // Random vectors against the arithmetic reference
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 2))
                    0:       rc[i] = 16'($signed(10'($urandom)));
                    1:       rc[i] = 16'($urandom);
                    default: rc[i] = 16'($signed(12'($urandom)));
                endcase
            end
            model(rc, rd, ro);
            run_vector($sformatf("rnd%0d", n), rc, rd, ro, int'($urandom_range(0, 3)), 1'b1,
                       1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case something above blocks unexpectedly
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end
endmodule
